fadd_share_arbiter: RTL

Round-robin arbiter and sequencer sharing one pipelined `FloatingAdd` datapath among `NUM_REQ` requesters. It accepts IEEE-754 single-precision add/subtract requests over per-requester valid/ready handshakes and issues at most one operation per cycle into the adder. It tracks each in-flight operation through a tag pipeline matched to the adder latency, and routes every result back to its originator. It sits between the execution units and a single `FloatingAdd` instance; the adder is instantiated outside this block and connected via the `add_*` ports.

---
 rtl/fadd_share_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fadd_share_arbiter.sv
// Round-robin arbiter sharing one pipelined FloatingAdd among NUM_REQ requesters.
// Grants one op per cycle, tracks in-flight ops with a tag pipe, and routes results back.
module fadd_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_sub,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_data,
    output logic [31:0]             add_a,
    output logic [31:0]             add_b,
    output logic                    add_sub,
    input  logic [31:0]             add_result
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state     [NUM_REQ];
    state_t             w_state_nxt [NUM_REQ];
    logic [IDW-1:0]     r_last_grant;
    logic [NUM_REQ-1:0] w_cand;
    logic               w_grant_vld;
    logic [IDW-1:0]     w_grant_id;
    int unsigned        w_idx;

    logic               r_iss_vld;
    logic [IDW-1:0]     r_iss_id;
    logic [ADD_LATENCY-1:0] r_tag_vld;
    logic [IDW-1:0]     r_tag_id [ADD_LATENCY];
    logic               w_tail_vld;
    logic [IDW-1:0]     w_tail_id;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (r_state[i] == ST_IDLE);
            w_cand[i]    = req_valid[i] & (r_state[i] == ST_IDLE);
        end
    end

    // Search starts one past the last winner and wraps; first candidate wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = (32'(r_last_grant) + k) % NUM_REQ;
            if (!w_grant_vld && w_cand[IDW'(w_idx)]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = IDW'(w_idx);
            end
        end
    end

    assign w_tail_vld = r_tag_vld[ADD_LATENCY-1];
    assign w_tail_id  = r_tag_id[ADD_LATENCY-1];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: if (w_grant_vld && (w_grant_id == IDW'(i))) w_state_nxt[i] = ST_BUSY;
                ST_BUSY: if (w_tail_vld && (w_tail_id == IDW'(i)))   w_state_nxt[i] = ST_IDLE;
                default: w_state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    // The issue tag rides alongside add_* for one cycle, then enters the
    // ADD_LATENCY-deep pipe so its tail lines up with the adder's output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) r_state[i] <= ST_IDLE;
            r_last_grant <= IDW'(NUM_REQ - 1);
            add_a        <= '0;
            add_b        <= '0;
            add_sub      <= 1'b0;
            r_iss_vld    <= 1'b0;
            r_iss_id     <= '0;
            r_tag_vld    <= '0;
            for (int unsigned k = 0; k < ADD_LATENCY; k++) r_tag_id[k] <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) r_state[i] <= w_state_nxt[i];
            if (w_grant_vld) begin
                r_last_grant <= w_grant_id;
                add_a        <= req_a[32*w_grant_id +: 32];
                add_b        <= req_b[32*w_grant_id +: 32];
                add_sub      <= req_sub[w_grant_id];
            end else begin
                add_a        <= '0;
                add_b        <= '0;
                add_sub      <= 1'b0;
            end
            r_iss_vld    <= w_grant_vld;
            r_iss_id     <= w_grant_id;
            r_tag_vld[0] <= r_iss_vld;
            r_tag_id[0]  <= r_iss_id;
            for (int unsigned k = 1; k < ADD_LATENCY; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
            if (w_tail_vld) begin
                rsp_valid <= NUM_REQ'(1) << w_tail_id;
                rsp_data  <= add_result;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

endmodule
